// File: rtl/feeder_pkg.sv
// Shared types and constants for the instruction feeder.
//   state_t : feeder FSM states
//   MV/MVI/ADD/SUB : proc opcodes found in DIN[8:6]
//   DEF_DATA_W : default instruction word width (proc DIN)
package feeder_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

    localparam logic [2:0] MV  = 3'b000;
    localparam logic [2:0] MVI = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011;

    localparam int DEF_DATA_W = 9;
endpackage

// File: rtl/instr_mem.sv
// Program memory: DEPTH x DATA_W register array.
//   Clock, Resetn : clock, async active-low reset (clears every word to 0)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
module instr_mem
    import feeder_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)  mem        <= '0;
        else if (we)  mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder for proc: presents mem[pc] on DIN, pulses Run for one
// cycle per instruction, waits for Done, then advances pc. For MVI the
// immediate word is mem[pc+1], visible on DIN during WAIT; pc skips it on Done.
// A watchdog forces ERR if Done does not arrive in time.
//   Clock, Resetn      : clock, async active-low reset (also clears memory)
//   Enable             : level, run program / stop after current instruction
//   Step               : single-step pulse, only honoured with FEEDER_STEP_EN
//   wr_en/addr/data    : program load port (accepted in IDLE and ERR only)
//   Done               : proc's last-cycle-of-instruction flag
//   DIN, Run           : to proc
//   pc, busy, error    : status
// Build option: define FEEDER_STEP_EN for single-step issue.
module instr_feeder
    import feeder_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 7
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Enable,
    input  logic              Step,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              Done,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              error
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state, nxt;
    logic [WD_W-1:0]   wdog;
    logic [2:0]        opcode;
    logic              en_q;
    logic              go;
    logic              mem_we;

    // Writes are only safe while nothing is in flight.
    assign mem_we = wr_en && (state == IDLE || state == ERR);

    instr_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .Clock  (Clock),
        .Resetn (Resetn),
        .we     (mem_we),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .raddr  (pc),
        .rdata  (DIN)
    );

`ifdef FEEDER_STEP_EN
    assign go = Enable && Step;
`else
    // Step is logically ignored; the redundant term keeps the port consumed.
    assign go = Enable | (Enable & Step);
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (go) nxt = ISSUE;
            ISSUE: nxt = WAIT;
            WAIT: begin
                // Done takes priority over an expiring watchdog.
                if (Done) begin
`ifdef FEEDER_STEP_EN
                    nxt = IDLE;
`else
                    nxt = Enable ? ISSUE : IDLE;
`endif
                end else if (wdog == WD_W'(TIMEOUT)) begin
                    nxt = ERR;
                end
            end
            ERR:   if (en_q && !Enable) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            pc     <= '0;
            wdog   <= '0;
            opcode <= MV;
            en_q   <= 1'b0;
        end else begin
            state <= nxt;
            en_q  <= Enable;
            case (state)
                ISSUE: begin
                    opcode <= DIN[DATA_W-1 -: 3];
                    pc     <= pc + 1'b1;
                    wdog   <= '0;
                end
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    // Skip over the immediate word consumed by MVI.
                    if (Done && opcode == MVI) pc <= pc + 1'b1;
                end
                ERR:     if (nxt == IDLE) pc <= '0;
                default: ;
            endcase
        end
    end

    assign Run   = (state == ISSUE);
    assign busy  = (state == ISSUE) || (state == WAIT);
    assign error = (state == ERR);
endmodule

// File: tb/tb_instr_feeder.sv
module tb_instr_feeder;
    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Enable = 1'b0;
    logic       Step = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [8:0] wr_data = '0;
    logic       Done = 1'b0;
    logic [8:0] DIN;
    logic       Run;
    logic [4:0] pc;
    logic       busy;
    logic       error;

    int n_chk = 0;
    int n_fail = 0;

    // {Run, busy, error, pc, DIN}
    logic [16:0] obs;
    assign obs = {Run, busy, error, pc, DIN};

    instr_feeder dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Enable  (Enable),
        .Step    (Step),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .Done    (Done),
        .DIN     (DIN),
        .Run     (Run),
        .pc      (pc),
        .busy    (busy),
        .error   (error)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [8:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        Enable = 1'b0; Step = 1'b0; Done = 1'b0; wr_en = 1'b0;
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [16:0] e;
        Resetn = 1'b0;
        #2;
        e = {1'b0, 1'b0, 1'b0, 5'd0, 9'h000};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL reset_async: got %b exp %b", obs, e); end
        tick();
        Resetn = 1'b1;
        tick();
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL reset_release: got %b exp %b", obs, e); end
    endtask

    // MVI R0,#5 then MV R1,R0; Run at cycles 1 and 4.
    task automatic test_mvi_mv();
        logic [16:0] e;
        load(5'd0, 9'h040);
        load(5'd1, 9'h005);
        load(5'd2, 9'h008);
        load(5'd3, 9'h081);
        Enable = 1'b1;
        tick();
        e = {1'b1, 1'b1, 1'b0, 5'd0, 9'h040};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t1_issue_mvi: got %b exp %b", obs, e); end
        tick();
        e = {1'b0, 1'b1, 1'b0, 5'd1, 9'h005};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t1_wait_imm: got %b exp %b", obs, e); end
        tick();
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t1_wait_imm2: got %b exp %b", obs, e); end
        Done = 1'b1;
        tick();
        e = {1'b1, 1'b1, 1'b0, 5'd2, 9'h008};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t1_issue_mv_b2b: got %b exp %b", obs, e); end
        Enable = 1'b0; Done = 1'b0;
        tick();
        e = {1'b0, 1'b1, 1'b0, 5'd3, 9'h081};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t1_wait_mv: got %b exp %b", obs, e); end
        Done = 1'b1;
        tick();
        Done = 1'b0;
        e = {1'b0, 1'b0, 1'b0, 5'd3, 9'h081};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t1_idle_pc3: got %b exp %b", obs, e); end
    endtask

    task automatic test_add();
        logic [16:0] e;
        Enable = 1'b1;
        tick();
        e = {1'b1, 1'b1, 1'b0, 5'd3, 9'h081};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t2_issue_add: got %b exp %b", obs, e); end
        Enable = 1'b0;
        tick();
        tick();
        tick();
        e = {1'b0, 1'b1, 1'b0, 5'd4, 9'h000};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t2_wait3: got %b exp %b", obs, e); end
        Done = 1'b1;
        tick();
        Done = 1'b0;
        e = {1'b0, 1'b0, 1'b0, 5'd4, 9'h000};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t2_idle_pc4: got %b exp %b", obs, e); end
    endtask

    task automatic test_watchdog();
        logic [16:0] e;
        do_reset();
        Enable = 1'b1;
        tick();
        tick();
        // Watchdog counts 0..TIMEOUT across eight WAIT cycles before ERR.
        for (int i = 0; i < 8; i++) begin
            e = {1'b0, 1'b1, 1'b0, 5'd1, 9'h000};
            n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t3_wait_%0d: got %b exp %b", i, obs, e); end
            if (i < 7) tick();
        end
        tick();
        e = {1'b0, 1'b0, 1'b1, 5'd1, 9'h000};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t3_err: got %b exp %b", obs, e); end
        // Writes are accepted in ERR.
        load(5'd0, 9'h1FF);
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t3_err_hold: got %b exp %b", obs, e); end
        Enable = 1'b0;
        tick();
        e = {1'b0, 1'b0, 1'b0, 5'd0, 9'h1FF};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t3_err_exit: got %b exp %b", obs, e); end
    endtask

    task automatic test_wrap();
        logic [16:0] e;
        do_reset();
        load(5'd0, 9'h00A);
        load(5'd31, 9'h040);
        Enable = 1'b1; Done = 1'b1;
        for (int k = 0; k < 31; k++) begin
            tick();
            e = {1'b1, 1'b1, 1'b0, 5'(k), (k == 0) ? 9'h00A : 9'h000};
            n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t4_issue_%0d: got %b exp %b", k, obs, e); end
            tick();
        end
        tick();
        e = {1'b1, 1'b1, 1'b0, 5'd31, 9'h040};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t4_issue31: got %b exp %b", obs, e); end
        Done = 1'b0;
        tick();
        e = {1'b0, 1'b1, 1'b0, 5'd0, 9'h00A};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t4_wrap_imm: got %b exp %b", obs, e); end
        Enable = 1'b0; Done = 1'b1;
        tick();
        Done = 1'b0;
        e = {1'b0, 1'b0, 1'b0, 5'd1, 9'h000};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t4_idle_pc1: got %b exp %b", obs, e); end
    endtask

    task automatic test_wr_ignore_stop();
        logic [16:0] e;
        load(5'd2, 9'h0C3);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        e = {1'b0, 1'b0, 1'b0, 5'd1, 9'h000};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t5_done_idle: got %b exp %b", obs, e); end
        Enable = 1'b1;
        tick();
        e = {1'b1, 1'b1, 1'b0, 5'd1, 9'h000};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t5_issue: got %b exp %b", obs, e); end
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 9'h155;
        tick();
        e = {1'b0, 1'b1, 1'b0, 5'd2, 9'h0C3};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t5_wr_issue: got %b exp %b", obs, e); end
        Enable = 1'b0;
        tick();
        wr_en = 1'b0;
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t5_wr_wait: got %b exp %b", obs, e); end
        Done = 1'b1;
        tick();
        Done = 1'b0;
        e = {1'b0, 1'b0, 1'b0, 5'd2, 9'h0C3};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t5_stop_idle: got %b exp %b", obs, e); end
    endtask

    task automatic test_step_reset();
        logic [16:0] e;
        do_reset();
        load(5'd0, 9'h040);
        load(5'd1, 9'h007);
        load(5'd2, 9'h008);
`ifdef FEEDER_STEP_EN
        begin
            int runs;
            logic [4:0] pcs [3];
            logic [8:0] dins [3];
            pcs = '{5'd2, 5'd3, 5'd4};
            dins = '{9'h008, 9'h000, 9'h000};
            runs = 0;
            Enable = 1'b1;
            tick();
            tick();
            e = {1'b0, 1'b0, 1'b0, 5'd0, 9'h040};
            n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t6_armed: got %b exp %b", obs, e); end
            for (int s = 0; s < 3; s++) begin
                Step = 1'b1;
                tick(); runs += int'(Run);
                Step = 1'b0;
                tick(); runs += int'(Run);
                Step = 1'b1; Done = 1'b1;
                tick(); runs += int'(Run);
                Step = 1'b0; Done = 1'b0;
                tick(); runs += int'(Run);
                e = {1'b0, 1'b0, 1'b0, pcs[s], dins[s]};
                n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t6_step_%0d: got %b exp %b", s, obs, e); end
            end
            n_chk++; if (runs !== 3) begin n_fail++; $display("FAIL t6_run_count: got %0d exp 3", runs); end
            do_reset();
            load(5'd0, 9'h040);
            Enable = 1'b1;
        end
        Step = 1'b1;
`else
        Step = 1'b1;
        tick();
        tick();
        e = {1'b0, 1'b0, 1'b0, 5'd0, 9'h040};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t6_step_ignored: got %b exp %b", obs, e); end
        Step = 1'b0;
        Enable = 1'b1;
`endif
        tick();
        Step = 1'b0;
        e = {1'b1, 1'b1, 1'b0, 5'd0, 9'h040};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t6_issue: got %b exp %b", obs, e); end
        tick();
        e = {1'b0, 1'b1, 1'b0, 5'd1, 9'h007};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t6_wait: got %b exp %b", obs, e); end
        Resetn = 1'b0;
        #1;
        e = {1'b0, 1'b0, 1'b0, 5'd0, 9'h000};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t6_reset_mid: got %b exp %b", obs, e); end
        Enable = 1'b0;
        tick();
        Resetn = 1'b1;
        tick();
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL t6_after_reset: got %b exp %b", obs, e); end
    endtask

    initial begin
        test_reset();
        test_mvi_mv();
        test_add();
        test_watchdog();
        test_wrap();
        test_wr_ignore_stop();
        test_step_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
